fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage plus IF/ID pipeline register of the 5-stage pipeline, directly upstream of decode.
//   Issues 16-bit instruction-word reads to instruction memory and presents {valid, instr, pc} to decode.
//   Consumes stallD from hazard_logic: holds decode's operands on a load-use stall.
//   Consumes a redirect (taken branch/jump resolved in EX), which squashes younger work.
// PARAMETERS
//   PC_W      32        PC / imem address width (word addressed, +1 per instruction)
//   INSTR_W   16        instruction word width; opcode = instr[15:9]
//   RESET_PC  32'h0     PC loaded on reset
// PORTS
//   clk             in   1        rising-edge clock
//   rst_n           in   1        asynchronous, active-low reset
//   imem_req        out  1        read request
//   imem_addr       out  PC_W     read address (= pc_q)
//   imem_ready      in   1        same-cycle acceptance; imem_rdata valid when req&&ready
//   imem_rdata      in   INSTR_W  returned instruction word
//   stallD          in   1        hold IF/ID register and PC (from hazard_logic)
//   redirect_valid  in   1        EX redirect; flushes IF/ID and skid
//   redirect_pc     in   PC_W     redirect target
//   id_valid        out  1        IF/ID holds a live instruction
//   id_instr        out  INSTR_W  IF/ID instruction
//   id_pc           out  PC_W     address of id_instr
//   id_pc_next      out  PC_W     id_pc + 1 (link/branch-base value)
// BEHAVIOUR
//   Reset (async, rst_n=0): pc_q=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc=0,
//     id_pc_next=0, skid_valid=0. imem_req=0 while rst_n=0; 1 from the first cycle after release.
//   FSM: FETCH (imem_req=1) and HOLD (imem_req=0, skid full).
//   Fetch hit := state==FETCH && imem_ready. imem_addr is always pc_q.
//   Priority each cycle: redirect_valid > stallD > normal.
//   redirect_valid=1: pc_q<=redirect_pc; id_valid<=0; skid_valid<=0; state<=FETCH.
//     Any same-cycle fetch hit is discarded. Redirect overrides a simultaneous stallD.
//   stallD=1, no redirect: IF/ID holds all fields.
//     Fetch hit: word+pc go to skid; skid_valid<=1; pc_q<=pc_q+1; state<=HOLD.
//   Normal (stallD=0, no redirect):
//     If skid_valid: IF/ID<=skid; skid_valid<=0; state<=FETCH; no request this cycle.
//     Else on fetch hit: IF/ID<={1, rdata, pc_q, pc_q+1}; pc_q<=pc_q+1.
//     Else (miss): id_valid<=0 (bubble), pc_q unchanged.
//   Latency: instruction accepted at edge N is visible on id_* after edge N (1 cycle).
//   A stall held across many cycles loses no word and duplicates no word.
//   PC arithmetic is modulo 2^PC_W; 0xFFFF_FFFF+1 wraps to 0 without a flag.
//   id_pc_next is computed with the same wrap.
//   imem_req never depends combinationally on stallD (no combinational loop through hazard_logic).
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
//     perf_stall_cnt increments on cycles with stallD && !redirect_valid.
//     perf_bubble_cnt increments on cycles where id_valid is written 0 (miss or redirect).
//     Both reset to 0 and saturate at 32'hFFFF_FFFF.
//   FETCH_PERF_CNT_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Shared package cpu_pkg holds: INSTR_W, PC_W, OPCODE_MSB/LSB, NOP_INSTR (16'h0),
//     and the FSM typedef fetch_state_t {FETCH, HOLD}.
//   One sub-module: fetch_skid_buf (1-entry {instr, pc} holding register with valid, load, clear).
//   PC register, FSM and IF/ID register live in fetch_stage.
// TESTING
//   1. Reset release, imem_ready=1, mem[i]=16'h1000+i
//      -> id_instr 16'h1000, 16'h1001, ... on consecutive cycles; id_pc 0, 1, 2; id_valid=1 from cycle 2.
//   2. stallD=1 for 3 cycles while id_instr=16'h1003
//      -> id_* held; imem_req=0 after skid fills.
//      On release, id_instr=16'h1004 then 16'h1005; none lost, none duplicated.
//   3. redirect_valid=1, redirect_pc=32'h40, with stallD=1 in the same cycle
//      -> id_valid=0 next cycle; imem_addr=32'h40; the next valid id_pc=32'h40.
//   4. imem_ready=0 for 2 cycles -> id_valid=0 for 2 cycles; imem_addr stable; resumes at same PC.
//   5. RESET_PC=32'hFFFF_FFFF -> id_pc 32'hFFFF_FFFF then 32'h0; first id_pc_next=32'h0.
//   6. rst_n pulsed low mid-stall with the skid full
//      -> id_valid=0 and imem_req=0 immediately (asynchronous); fetch restarts at RESET_PC.
//   FETCH_PERF_CNT_EN builds: in scenario 2, perf_stall_cnt advances by 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, opcode field bounds and fetch FSM encoding for the core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int PC_W       = 32;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 9;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module : fetch_skid_buf
// Brief  : One-entry {instr, pc} holding register; clear has priority over load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int PC_W_P    = PC_W,
    parameter int INSTR_W_P = INSTR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [INSTR_W_P-1:0] instr_i,
    input  logic [PC_W_P-1:0]    pc_i,
    output logic                 valid_o,
    output logic [INSTR_W_P-1:0] instr_o,
    output logic [PC_W_P-1:0]    pc_o
);

    logic                 valid_q;
    logic [INSTR_W_P-1:0] instr_q;
    logic [PC_W_P-1:0]    pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : IF stage plus IF/ID register with stall skid and EX redirect.
//          Optional FETCH_PERF_CNT_EN adds saturating stall/bubble counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                 PC_W     = cpu_pkg::PC_W,
    parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stallD,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_next
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic [PC_W-1:0]    id_pc_next_q, id_pc_next_d;

    logic               w_hit;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc;
    logic [PC_W-1:0]    w_pc_inc;

    // Request depends only on reset and FSM state, never on stallD.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;
    assign w_hit     = imem_req && imem_ready;
    assign w_pc_inc  = pc_q + C_PC_ONE;

    fetch_skid_buf #(
        .PC_W_P    (PC_W),
        .INSTR_W_P (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_skid_load),
        .clear_i (w_skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (w_skid_valid),
        .instr_o (w_skid_instr),
        .pc_o    (w_skid_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            id_valid_d   = 1'b0;
            w_skid_clear = 1'b1;
            state_d      = FETCH;
        end else if (stallD) begin
            // Word returned during a stall parks in the skid so nothing is refetched.
            if (w_hit) begin
                w_skid_load = 1'b1;
                pc_d        = w_pc_inc;
                state_d     = HOLD;
            end
        end else if (w_skid_valid) begin
            id_valid_d   = 1'b1;
            id_instr_d   = w_skid_instr;
            id_pc_d      = w_skid_pc;
            id_pc_next_d = w_skid_pc + C_PC_ONE;
            w_skid_clear = 1'b1;
            state_d      = FETCH;
        end else if (w_hit) begin
            id_valid_d   = 1'b1;
            id_instr_d   = imem_rdata;
            id_pc_d      = pc_q;
            id_pc_next_d = w_pc_inc;
            pc_d         = w_pc_inc;
        end else begin
            id_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= '0;
            id_pc_next_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign id_instr   = id_instr_q;
    assign id_pc      = id_pc_q;
    assign id_pc_next = id_pc_next_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_bubble_q;
    logic        w_stall_evt;
    logic        w_bubble_evt;

    assign w_stall_evt  = stallD && !redirect_valid;
    assign w_bubble_evt = redirect_valid ||
                          (!stallD && !w_skid_valid && !w_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (w_stall_evt && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (w_bubble_evt && (perf_bubble_q != 32'hFFFF_FFFF)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = perf_stall_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed self-checking bench for fetch_stage (two instances, one
//          with RESET_PC at the top of the address space).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        stallD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;

    logic        rst2_n;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [15:0] imem_rdata2;
    logic        id_valid2;
    logic [15:0] id_instr2;
    logic [31:0] id_pc2;
    logic [31:0] id_pc_next2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
    logic [31:0] perf_stall_cnt2, perf_bubble_cnt2;
    logic [31:0] stall_base;
`endif

    int errors = 0;
    int checks = 0;

    // Memory model: mem[i] = 16'h1000 + i
    assign imem_rdata  = 16'h1000 + imem_addr[15:0];
    assign imem_rdata2 = 16'h1000 + imem_addr2[15:0];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stallD         (stallD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_next     (id_pc_next)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFFF)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst2_n),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_ready     (1'b1),
        .imem_rdata     (imem_rdata2),
        .stallD         (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .id_valid       (id_valid2),
        .id_instr       (id_instr2),
        .id_pc          (id_pc2),
        .id_pc_next     (id_pc_next2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt2),
        .perf_bubble_cnt (perf_bubble_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [15:0] ins,
                            input logic [31:0] pc, input logic [31:0] pcn);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, ".instr"}, {16'd0, id_instr}, {16'd0, ins});
        check({tag, ".pc"}, id_pc, pc);
        check({tag, ".pc_next"}, id_pc_next, pcn);
    endtask

    initial begin
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        imem_ready     = 1'b1;
        stallD         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();

        // Reset state
        check_id("rst", 1'b0, 16'h0, 32'h0, 32'h0);
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check("rst.addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        // 1: streaming fetch
        step();
        check_id("s1.c1", 1'b1, 16'h1000, 32'h0, 32'h1);
        check("s1.req", {31'd0, imem_req}, 32'd1);
        step();
        check_id("s1.c2", 1'b1, 16'h1001, 32'h1, 32'h2);
        step();
        check_id("s1.c3", 1'b1, 16'h1002, 32'h2, 32'h3);
        step();
        check_id("s1.c4", 1'b1, 16'h1003, 32'h3, 32'h4);

        // 2: three-cycle stall while 16'h1003 sits in IF/ID
`ifdef FETCH_PERF_CNT_EN
        stall_base = perf_stall_cnt;
`endif
        stallD = 1'b1;
        step();
        check_id("s2.st1", 1'b1, 16'h1003, 32'h3, 32'h4);
        check("s2.req_after_skid", {31'd0, imem_req}, 32'd0);
        check("s2.addr", imem_addr, 32'h5);
        step();
        check_id("s2.st2", 1'b1, 16'h1003, 32'h3, 32'h4);
        check("s2.req_hold", {31'd0, imem_req}, 32'd0);
        step();
        check_id("s2.st3", 1'b1, 16'h1003, 32'h3, 32'h4);
        stallD = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("s2.perf_stall", perf_stall_cnt - stall_base, 32'd3);
`endif
        step();
        check_id("s2.rel1", 1'b1, 16'h1004, 32'h4, 32'h5);
        check("s2.req_resume", {31'd0, imem_req}, 32'd1);
        step();
        check_id("s2.rel2", 1'b1, 16'h1005, 32'h5, 32'h6);

        // 3: redirect overrides simultaneous stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        stallD         = 1'b1;
        step();
        check("s3.valid", {31'd0, id_valid}, 32'd0);
        check("s3.addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        stallD         = 1'b0;
        step();
        check_id("s3.first", 1'b1, 16'h1040, 32'h40, 32'h41);

        // 4: memory not ready for two cycles
        imem_ready = 1'b0;
        step();
        check("s4.b1.valid", {31'd0, id_valid}, 32'd0);
        check("s4.b1.addr", imem_addr, 32'h41);
        step();
        check("s4.b2.valid", {31'd0, id_valid}, 32'd0);
        check("s4.b2.addr", imem_addr, 32'h41);
        imem_ready = 1'b1;
        step();
        check_id("s4.resume", 1'b1, 16'h1041, 32'h41, 32'h42);

        // 6: asynchronous reset mid-stall with skid full
        stallD = 1'b1;
        step();
        check("s6.skidfull.req", {31'd0, imem_req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6.async.valid", {31'd0, id_valid}, 32'd0);
        check("s6.async.req", {31'd0, imem_req}, 32'd0);
        check("s6.async.addr", imem_addr, 32'h0);
        rst_n  = 1'b1;
        stallD = 1'b0;
        step();
        check_id("s6.restart", 1'b1, 16'h1000, 32'h0, 32'h1);
        step();
        check_id("s6.next", 1'b1, 16'h1001, 32'h1, 32'h2);

        // 5: PC wrap from 32'hFFFF_FFFF
        check("s5.rst.valid", {31'd0, id_valid2}, 32'd0);
        check("s5.rst.addr", imem_addr2, 32'hFFFF_FFFF);
        rst2_n = 1'b1;
        step();
        check("s5.c1.valid", {31'd0, id_valid2}, 32'd1);
        check("s5.c1.pc", id_pc2, 32'hFFFF_FFFF);
        check("s5.c1.pc_next", id_pc_next2, 32'h0);
        check("s5.c1.instr", {16'd0, id_instr2}, 32'h0FFF);
        step();
        check("s5.c2.pc", id_pc2, 32'h0);
        check("s5.c2.pc_next", id_pc_next2, 32'h1);
        check("s5.c2.instr", {16'd0, id_instr2}, 32'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
